// File: rtl/seg_pkg.sv
// Shared types, constants and the leading-zero helper for the
// multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic [0:0] {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = 8'hFF;
  localparam logic                  DP_OFF    = 1'b1;

  // Bit i is set when digit i and every digit above it are zero; digit 0 is never set.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [DIGIT_W*MAX_DIGITS-1:0] shadow,
    input int                            num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_run;
    mask     = {MAX_DIGITS{1'b0}};
    zero_run = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < num_digits) begin
        zero_run = zero_run & (shadow[DIGIT_W*i +: DIGIT_W] == 4'd0);
        mask[i]  = zero_run;
      end else begin
        mask[i]  = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module seg_scan_timer #(
  parameter int               CNT_W     = 17,
  parameter logic [CNT_W-1:0] RESET_VAL = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_r;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= RESET_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered BCD digits,
// guard slots between digits, and optional leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          update,
  input  logic                          lz_en,
  output logic [DIGIT_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          dp_n,
  output logic                          frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SHOW_LOAD  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = ANODE_OFF[NUM_DIGITS-1:0];

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_vec_t;

  state_e                  state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  digit_vec_t              shadow_r, shadow_s, staging_r, staging_s;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, shadow_dp_s, staging_dp_r, staging_dp_s;
  logic                    pending_r, pending_s;
  logic [DIGIT_W-1:0]      digit_code_r, digit_code_s;
  logic [NUM_DIGITS-1:0]   an_n_r, an_n_s, an_sel_s;
  logic                    dp_n_r, dp_n_s;
  logic                    frame_done_r, frame_end_s;
  logic                    tc_s;
  logic [CNT_W-1:0]        load_val_s;
  logic [MAX_DIGITS-1:0]   lz_mask_s;

  // The counter is reloaded on every state change, so each phase starts fresh.
  assign load_val_s = (state_r == GUARD) ? SHOW_LOAD : GUARD_LOAD;

  seg_scan_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (GUARD_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tc_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  assign lz_mask_s = lz_mask((DIGIT_W*MAX_DIGITS)'(shadow_r), NUM_DIGITS);
  assign an_sel_s  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r);

  // Slot sequencing and next values of the anode / decimal-point outputs.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    an_n_s      = an_n_r;
    dp_n_s      = dp_n_r;
    frame_end_s = 1'b0;
    case (state_r)
      GUARD: begin
        if (tc_s) begin
          state_s = SHOW;
          if (lz_en && lz_mask_s[idx_r]) begin
            an_n_s = AN_OFF;
            dp_n_s = DP_OFF;
          end else begin
            an_n_s = an_sel_s;
            dp_n_s = ~shadow_dp_r[idx_r];
          end
        end else begin
          an_n_s = AN_OFF;
          dp_n_s = DP_OFF;
        end
      end
      SHOW: begin
        if (tc_s) begin
          state_s     = GUARD;
          an_n_s      = AN_OFF;
          dp_n_s      = DP_OFF;
          frame_end_s = (idx_r == LAST_IDX);
          idx_s       = frame_end_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
        end else begin
          an_n_s = an_n_r;
          dp_n_s = dp_n_r;
        end
      end
      default: begin
        state_s = GUARD;
        idx_s   = {IDX_W{1'b0}};
        an_n_s  = AN_OFF;
        dp_n_s  = DP_OFF;
      end
    endcase
  end

  // Double buffer: shadow only changes at frame end; an update on that cycle bypasses staging.
  always_comb begin
    shadow_s     = shadow_r;
    shadow_dp_s  = shadow_dp_r;
    staging_s    = staging_r;
    staging_dp_s = staging_dp_r;
    pending_s    = pending_r;
    if (frame_end_s) begin
      if (update) begin
        shadow_s    = digits_in;
        shadow_dp_s = dp_in;
      end else if (pending_r) begin
        shadow_s    = staging_r;
        shadow_dp_s = staging_dp_r;
      end else begin
        shadow_s    = shadow_r;
        shadow_dp_s = shadow_dp_r;
      end
      pending_s = 1'b0;
    end else if (update) begin
      staging_s    = digits_in;
      staging_dp_s = dp_in;
      pending_s    = 1'b1;
    end else begin
      pending_s = pending_r;
    end
    digit_code_s = shadow_s[idx_s];
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= GUARD;
      idx_r        <= {IDX_W{1'b0}};
      shadow_r     <= {(DIGIT_W*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      staging_r    <= {(DIGIT_W*NUM_DIGITS){1'b0}};
      staging_dp_r <= {NUM_DIGITS{1'b0}};
      pending_r    <= 1'b0;
      digit_code_r <= {DIGIT_W{1'b0}};
      an_n_r       <= AN_OFF;
      dp_n_r       <= DP_OFF;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      shadow_r     <= shadow_s;
      shadow_dp_r  <= shadow_dp_s;
      staging_r    <= staging_s;
      staging_dp_r <= staging_dp_s;
      pending_r    <= pending_s;
      digit_code_r <= digit_code_s;
      an_n_r       <= an_n_s;
      dp_n_r       <= dp_n_s;
      frame_done_r <= frame_end_s;
    end
  end

  assign digit_code = digit_code_r;
  assign an_n       = an_n_r;
  assign dp_n       = dp_n_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl; expected outputs come from a
// frame/slot arithmetic model driven by the same input stream.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int GC    = 2;
  localparam int SLOT  = RD + GC;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_code;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  // Reference model: k = edges since reset release
  int          k;
  logic [15:0] m_cur, m_stag;
  logic [3:0]  m_cur_dp, m_stag_dp;
  bit          m_pend, m_sup;
  logic [9:0]  got_v, exp_v;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .update     (update),
    .lz_en      (lz_en),
    .digit_code (digit_code),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    k = 0; m_cur = 16'h0; m_stag = 16'h0; m_cur_dp = 4'h0; m_stag_dp = 4'h0;
    m_pend = 1'b0; m_sup = 1'b0;
  endtask

  task automatic model_edge();
    int pos, slot;
    k++;
    pos  = k % FRAME;
    slot = pos / SLOT;
    if (pos == 0) begin
      if (update) begin
        m_cur = digits_in; m_cur_dp = dp_in;
      end else if (m_pend) begin
        m_cur = m_stag; m_cur_dp = m_stag_dp;
      end
      m_pend = 1'b0;
    end else if (update) begin
      m_stag = digits_in; m_stag_dp = dp_in; m_pend = 1'b1;
    end
    if (pos % SLOT == GC)
      m_sup = lz_en && (slot > 0) && ((m_cur >> (4 * slot)) == 16'h0);
  endtask

  // {an_n, dp_n, digit_code, frame_done} expected right after edge k
  function automatic logic [9:0] exp_vec();
    int pos, slot;
    bit lit;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] sh;
    pos  = k % FRAME;
    slot = pos / SLOT;
    lit  = (pos % SLOT >= GC) && !m_sup;
    an   = 4'hF;
    dp   = 1'b1;
    sh   = m_cur >> (4 * slot);
    if (lit) begin
      an[slot] = 1'b0;
      dp = ~m_cur_dp[slot];
    end
    return {an, dp, sh[3:0], (pos == 0 && k > 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    update = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; update = 1'b0; lz_en = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
    repeat (3) @(negedge clk);
    total++; if (an_n !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=1111", an_n); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp_n); end
    total++; if (digit_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h want=0", digit_code); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL reset_seq k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
  endtask

  task automatic test_update();
    int fd_cnt = 0;
    while (k < 2 * FRAME) begin
      if (k + 1 == 10) begin digits_in = 16'h4321; dp_in = 4'h0; update = 1'b1; end
      tick();
      if (frame_done === 1'b1) fd_cnt++;
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL update k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
    total++; if (fd_cnt !== 2) begin bad++; $display("FAIL frame_done_count got=%0d want=2", fd_cnt); end
  endtask

  task automatic test_mid_frame();
    int base = k;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (k + 1 - base == 9) begin digits_in = 16'h9876; update = 1'b1; end
      if (k + 1 - base == FRAME + 3) begin digits_in = 16'h5555; update = 1'b1; end
      if (k + 1 - base == FRAME + 15) begin digits_in = 16'h1111; update = 1'b1; end
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL mid_frame k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
  endtask

  task automatic test_bypass();
    int base = k;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (k + 1 - base == 10) begin digits_in = 16'($urandom); dp_in = 4'($urandom); update = 1'b1; end
      if (k + 1 - base == FRAME) begin digits_in = 16'($urandom); dp_in = 4'($urandom); update = 1'b1; end
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL bypass k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
  endtask

  task automatic test_lz();
    int base = k;
    lz_en = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (k + 1 - base == 1) begin digits_in = 16'h0050; dp_in = 4'h0; update = 1'b1; end
      if (k + 1 - base == FRAME + 6) begin digits_in = 16'h0000; dp_in = 4'b0100; update = 1'b1; end
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL lz k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_dp();
    int base = k;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (k + 1 - base == 1) begin digits_in = 16'($urandom) | 16'h1000; dp_in = 4'b0100; update = 1'b1; end
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL dp k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10 * FRAME; c++) begin
      if ($urandom_range(7) == 0) begin
        digits_in = 16'($urandom) >> (4 * $urandom_range(4));
        dp_in = 4'($urandom);
        update = 1'b1;
      end
      if ($urandom_range(31) == 0) lz_en = ~lz_en;
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL random k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int  start_frame = k / FRAME;
    bit  hit = 1'b0;
    digits_in = 16'h5678; dp_in = 4'b0100; update = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL pre_reset k=%0d got=%b want=%b", k, got_v, exp_v); end
      if (k / FRAME > start_frame && k % FRAME == 2 * SLOT + GC + 1) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL reach_slot2 got=0 want=1"); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (an_n !== 4'b1111) begin bad++; $display("FAIL async_an got=%b want=1111", an_n); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL async_dp got=%b want=1", dp_n); end
    total++; if (digit_code !== 4'h0) begin bad++; $display("FAIL async_code got=%h want=0", digit_code); end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      got_v = {an_n, dp_n, digit_code, frame_done}; exp_v = exp_vec(); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL post_reset k=%0d got=%b want=%b", k, got_v, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_update();
    test_mid_frame();
    test_bypass();
    test_lz();
    test_dp();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
